// File: rtl/csi_pkg.sv
// rtl/csi_pkg.sv - shared CSI-2 protocol types, constants, ECC and CRC helpers
package csi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC,
    WAIT_EOT
  } csi_state_t;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_RAW8      = 6'h2A;
  localparam logic [5:0] DT_RAW10     = 6'h2B;
  localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

  // Parity coverage of each ECC bit over {WC[15:0], DI[7:0]}
  localparam logic [23:0] ECC_MASK_0 = 24'hF12CB7;
  localparam logic [23:0] ECC_MASK_1 = 24'hF2555B;
  localparam logic [23:0] ECC_MASK_2 = 24'h749A6D;
  localparam logic [23:0] ECC_MASK_3 = 24'hB8E38E;
  localparam logic [23:0] ECC_MASK_4 = 24'hDF03F0;
  localparam logic [23:0] ECC_MASK_5 = 24'hEFFC00;

  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & ECC_MASK_0);
    p[1] = ^(d & ECC_MASK_1);
    p[2] = ^(d & ECC_MASK_2);
    p[3] = ^(d & ECC_MASK_3);
    p[4] = ^(d & ECC_MASK_4);
    p[5] = ^(d & ECC_MASK_5);
    return p;
  endfunction

  // Reflected CRC-16 (0x8408), data consumed LSB first
  function automatic logic [15:0] csi_crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/csi_crc16.sv
// rtl/csi_crc16.sv - byte-wide running CRC-16 accumulator
module csi_crc16
  import csi_pkg::*;
(
  input  logic        hs_clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc
);

  always_ff @(posedge hs_clk) begin
    if (rst || clear) crc <= 16'hFFFF;
    else if (enable)  crc <= csi_crc16_byte(crc, byte_in);
  end

endmodule

// File: rtl/csi_slave_protocol_layer.sv
// rtl/csi_slave_protocol_layer.sv - CSI-2 receive packet parser (header ECC, payload, CRC)
module csi_slave_protocol_layer
  import csi_pkg::*;
#(
  parameter logic [15:0] MAX_WC = 16'hFFFF
) (
  input  logic        hs_clk,
  input  logic        rst,
  input  logic        rx_active_hs,
  input  logic        rx_sync_hs,
  input  logic        rx_valid_hs,
  input  logic [7:0]  rx_byte_hs,
  output logic        hdr_valid,
  output logic [1:0]  hdr_vc,
  output logic [5:0]  hdr_dt,
  output logic [15:0] hdr_wc,
  output logic        hdr_short,
  output logic        data_valid,
  output logic [7:0]  data,
  output logic        data_last,
  output logic        pkt_done,
  output logic        crc_err,
  output logic        ecc_err,
  output logic        trunc_err
);

  csi_state_t  state;
  logic [1:0]  byte_cnt;
  logic [7:0]  di;
  logic [7:0]  wc_lo;
  logic [7:0]  wc_hi;
  logic [15:0] remaining;
  logic        crc_lo_ok;
  logic [15:0] crc_val;
  logic [5:0]  syndrome;
  logic        wc_too_big;
  logic        is_short;

  assign syndrome   = csi_ecc({wc_hi, wc_lo, di}) ^ rx_byte_hs[5:0];
  assign wc_too_big = {16'd0, wc_hi, wc_lo} > {16'd0, MAX_WC};
  assign is_short   = di[5:0] <= SHORT_DT_MAX;

  // CRC sits at its init value whenever no packet is open
  csi_crc16 u_crc (
    .hs_clk  (hs_clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  ((state == PAYLOAD) && rx_active_hs && rx_valid_hs),
    .byte_in (rx_byte_hs),
    .crc     (crc_val)
  );

  always_ff @(posedge hs_clk) begin
    hdr_valid  <= 1'b0;
    data_valid <= 1'b0;
    data_last  <= 1'b0;
    pkt_done   <= 1'b0;
    crc_err    <= 1'b0;
    ecc_err    <= 1'b0;
    trunc_err  <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= 2'd0;
      di        <= 8'd0;
      wc_lo     <= 8'd0;
      wc_hi     <= 8'd0;
      remaining <= 16'd0;
      crc_lo_ok <= 1'b0;
      hdr_vc    <= 2'd0;
      hdr_dt    <= 6'd0;
      hdr_wc    <= 16'd0;
      hdr_short <= 1'b0;
      data      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid_hs && rx_sync_hs) begin
            di       <= rx_byte_hs;
            byte_cnt <= 2'd1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (!rx_active_hs) begin
            trunc_err <= 1'b1;
            state     <= IDLE;
          end else if (rx_valid_hs) begin
            case (byte_cnt)
              2'd1: begin
                wc_lo    <= rx_byte_hs;
                byte_cnt <= 2'd2;
              end
              2'd2: begin
                wc_hi    <= rx_byte_hs;
                byte_cnt <= 2'd3;
              end
              default: begin
                byte_cnt <= 2'd0;
                if (syndrome != 6'd0 || wc_too_big) begin
                  ecc_err <= 1'b1;
                  state   <= WAIT_EOT;
                end else begin
                  hdr_valid <= 1'b1;
                  hdr_vc    <= di[7:6];
                  hdr_dt    <= di[5:0];
                  hdr_wc    <= {wc_hi, wc_lo};
                  hdr_short <= is_short;
                  remaining <= {wc_hi, wc_lo};
                  if (is_short)                     state <= WAIT_EOT;
                  else if ({wc_hi, wc_lo} == 16'd0) state <= CRC;
                  else                              state <= PAYLOAD;
                end
              end
            endcase
          end
        end
        PAYLOAD: begin
          if (!rx_active_hs) begin
            trunc_err <= 1'b1;
            state     <= IDLE;
          end else if (rx_valid_hs) begin
            data       <= rx_byte_hs;
            data_valid <= 1'b1;
            remaining  <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              data_last <= 1'b1;
              byte_cnt  <= 2'd0;
              state     <= CRC;
            end
          end
        end
        CRC: begin
          if (!rx_active_hs) begin
            trunc_err <= 1'b1;
            state     <= IDLE;
          end else if (rx_valid_hs) begin
            if (byte_cnt == 2'd0) begin
              crc_lo_ok <= (rx_byte_hs == crc_val[7:0]);
              byte_cnt  <= 2'd1;
            end else begin
              pkt_done <= 1'b1;
              crc_err  <= !(crc_lo_ok && (rx_byte_hs == crc_val[15:8]));
              state    <= WAIT_EOT;
            end
          end
        end
        WAIT_EOT: begin
          if (!rx_active_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi_slave_protocol_layer.sv
// tb/tb_csi_slave_protocol_layer.sv - directed bench for the CSI-2 receive parser
module tb_csi_slave_protocol_layer;
  import csi_pkg::*;

  logic        hs_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_active_hs = 1'b0;
  logic        rx_sync_hs = 1'b0;
  logic        rx_valid_hs = 1'b0;
  logic [7:0]  rx_byte_hs = 8'd0;
  logic        hdr_valid;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        hdr_short;
  logic        data_valid;
  logic [7:0]  data;
  logic        data_last;
  logic        pkt_done;
  logic        crc_err;
  logic        ecc_err;
  logic        trunc_err;

  csi_slave_protocol_layer dut (
    .hs_clk(hs_clk), .rst(rst),
    .rx_active_hs(rx_active_hs), .rx_sync_hs(rx_sync_hs),
    .rx_valid_hs(rx_valid_hs), .rx_byte_hs(rx_byte_hs),
    .hdr_valid(hdr_valid), .hdr_vc(hdr_vc), .hdr_dt(hdr_dt), .hdr_wc(hdr_wc),
    .hdr_short(hdr_short), .data_valid(data_valid), .data(data), .data_last(data_last),
    .pkt_done(pkt_done), .crc_err(crc_err), .ecc_err(ecc_err), .trunc_err(trunc_err)
  );

  always #5 hs_clk = ~hs_clk;

  int cyc = 0;
  always @(posedge hs_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Strobe monitor: accumulates events; the stimulus block works on deltas
  int n_hdr = 0, n_data = 0, n_last = 0, n_done = 0, n_ecc = 0, n_trunc = 0;
  int last_pos = 0, hdr_cyc = 0, ecc_cyc = 0, trunc_cyc = 0, done_cyc = 0;
  logic cap_short = 1'b0;
  logic cap_crc_err = 1'b0;
  logic [7:0] dq[$];
  int dcyc[$];

  always @(negedge hs_clk) begin
    if (hdr_valid) begin
      n_hdr     <= n_hdr + 1;
      hdr_cyc   <= cyc;
      cap_short <= hdr_short;
    end
    if (data_valid) begin
      dq.push_back(data);
      dcyc.push_back(cyc);
      n_data <= n_data + 1;
      if (data_last) begin
        n_last   <= n_last + 1;
        last_pos <= n_data + 1;
      end
    end
    if (pkt_done) begin
      n_done      <= n_done + 1;
      done_cyc    <= cyc;
      cap_crc_err <= crc_err;
    end
    if (ecc_err) begin
      n_ecc   <= n_ecc + 1;
      ecc_cyc <= cyc;
    end
    if (trunc_err) begin
      n_trunc   <= n_trunc + 1;
      trunc_cyc <= cyc;
    end
  end

  int b_hdr, b_data, b_last, b_done, b_ecc, b_trunc;
  int drv_cyc[64];
  logic [7:0] tx[$];
  logic [7:0] p24[$] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
                         8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
                         8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};
  logic [7:0] p16[$];
  logic [15:0] c16;
  logic [5:0] short_dts[2];
  logic [7:0] short_ecc[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_hdr = n_hdr; b_data = n_data; b_last = n_last;
    b_done = n_done; b_ecc = n_ecc; b_trunc = n_trunc;
  endtask

  function automatic logic [15:0] crc_model(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[k]) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ q[k][j]) c = (c >> 1) ^ 16'h8408;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  // Drive tx as one HS burst; cut >= 0 drops rx_active_hs before byte 'cut'
  task automatic send(input bit gaps, input int cut);
    for (int i = 0; i < tx.size(); i++) begin
      if (cut >= 0 && i == cut) break;
      if (gaps && i > 0) begin
        @(posedge hs_clk); #1;
        rx_valid_hs = 1'b0; rx_sync_hs = 1'b0;
      end
      @(posedge hs_clk); #1;
      rx_active_hs = 1'b1; rx_valid_hs = 1'b1; rx_sync_hs = (i == 0);
      rx_byte_hs = tx[i]; drv_cyc[i] = cyc;
    end
    @(posedge hs_clk); #1;
    rx_active_hs = 1'b0; rx_valid_hs = 1'b0; rx_sync_hs = 1'b0;
    repeat (4) @(posedge hs_clk);
    @(negedge hs_clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {24'd0, hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_short, data_valid, data,
            data_last, pkt_done, crc_err, ecc_err, trunc_err};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) p16.push_back(8'(i * 17 + 3));
    short_dts[0] = DT_LS; short_dts[1] = DT_LE;
    short_ecc[0] = 8'h0B; short_ecc[1] = 8'h0C;

    repeat (3) @(posedge hs_clk);
    @(negedge hs_clk);
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge hs_clk);

    chk("crc_model_ref", 64'(crc_model(p24)), 64'hE569);

    // Short FS packet
    snap();
    tx = '{{2'b00, DT_FS}, 8'h01, 8'h00, 8'h1A};
    send(1'b0, -1);
    chk("fs_hdr_count", n_hdr - b_hdr, 1);
    chk("fs_hdr_short", cap_short, 1);
    chk("fs_hdr_fields", {hdr_vc, hdr_dt, hdr_wc}, {2'd0, 6'h00, 16'h0001});
    chk("fs_hdr_timing", hdr_cyc, drv_cyc[3] + 1);
    chk("fs_no_data", n_data - b_data, 0);
    chk("fs_no_done", n_done - b_done, 0);

    // LS / LE short packets, WC = 0
    for (int s = 0; s < 2; s++) begin
      snap();
      tx = '{{2'b00, short_dts[s]}, 8'h00, 8'h00, short_ecc[s]};
      send(1'b0, -1);
      chk($sformatf("short%0d_hdr", s), {32'(n_hdr - b_hdr), 7'd0, cap_short, 2'd0, hdr_dt},
          {32'd1, 7'd0, 1'b1, 2'd0, short_dts[s]});
    end

    // Long RAW8, 24 bytes, good CRC
    snap();
    tx = '{{2'b00, DT_RAW8}, 8'h18, 8'h00, 8'h13};
    foreach (p24[i]) tx.push_back(p24[i]);
    tx.push_back(8'h69); tx.push_back(8'hE5);
    send(1'b0, -1);
    chk("raw8_hdr", {32'(n_hdr - b_hdr), 7'd0, cap_short, hdr_dt, hdr_wc}, {32'd1, 8'd0, DT_RAW8, 16'h0018});
    chk("raw8_data_count", n_data - b_data, 24);
    for (int i = 0; i < 24; i++) chk($sformatf("raw8_byte%0d", i), dq[b_data + i], p24[i]);
    chk("raw8_first_timing", dcyc[b_data], drv_cyc[4] + 1);
    chk("raw8_last", {32'(n_last - b_last), 32'(last_pos)}, {32'd1, 32'(b_data + 24)});
    chk("raw8_done", {32'(n_done - b_done), 31'd0, cap_crc_err}, {32'd1, 32'd0});
    chk("raw8_done_timing", done_cyc, drv_cyc[29] + 1);

    // Same packet, corrupted CRC MSB
    snap();
    tx[29] = 8'hE4;
    send(1'b0, -1);
    chk("badcrc_data_count", n_data - b_data, 24);
    chk("badcrc_done", {32'(n_done - b_done), 31'd0, cap_crc_err}, {32'd1, 32'd1});

    // RAW10 header with WC bit 3 flipped after ECC generation
    snap();
    tx = '{{2'b00, DT_RAW10}, 8'h10, 8'h00, 8'h14, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send(1'b0, -1);
    chk("ecc_pulse", n_ecc - b_ecc, 1);
    chk("ecc_timing", ecc_cyc, drv_cyc[3] + 1);
    chk("ecc_no_hdr_data_done", {32'(n_hdr - b_hdr), 32'(n_data - b_data + n_done - b_done)}, 64'd0);

    // Long packet with WC = 0: header then CRC of nothing
    snap();
    tx = '{{2'b00, DT_RAW8}, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF};
    send(1'b0, -1);
    chk("wc0_hdr", {32'(n_hdr - b_hdr), hdr_wc}, {32'd1, 16'h0000});
    chk("wc0_no_data", n_data - b_data, 0);
    chk("wc0_done", {32'(n_done - b_done), 31'd0, cap_crc_err}, {32'd1, 32'd0});

    // WC = 16 with rx_valid_hs low every other cycle
    snap();
    c16 = crc_model(p16);
    tx = '{{2'b00, DT_RAW8}, 8'h10, 8'h00, 8'h36};
    foreach (p16[i]) tx.push_back(p16[i]);
    tx.push_back(c16[7:0]); tx.push_back(c16[15:8]);
    send(1'b1, -1);
    chk("gap_data_count", n_data - b_data, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("gap_byte%0d", i), dq[b_data + i], p16[i]);
    chk("gap_last", {32'(n_last - b_last), 32'(last_pos)}, {32'd1, 32'(b_data + 16)});
    chk("gap_done", {32'(n_done - b_done), 31'd0, cap_crc_err}, {32'd1, 32'd0});

    // Burst dropped after 5 of 16 payload bytes
    snap();
    send(1'b0, 9);
    chk("trunc_data_count", n_data - b_data, 5);
    chk("trunc_pulse", n_trunc - b_trunc, 1);
    chk("trunc_timing", trunc_cyc, drv_cyc[8] + 2);
    chk("trunc_no_last_done", {32'(n_last - b_last), 32'(n_done - b_done)}, 64'd0);

    // Reset mid-header
    snap();
    tx = '{{2'b00, DT_RAW8}, 8'h18};
    for (int i = 0; i < 2; i++) begin
      @(posedge hs_clk); #1;
      rx_active_hs = 1'b1; rx_valid_hs = 1'b1; rx_sync_hs = (i == 0); rx_byte_hs = tx[i];
    end
    @(posedge hs_clk); #1;
    rx_valid_hs = 1'b0; rx_sync_hs = 1'b0; rst = 1'b1;
    @(posedge hs_clk); #1;
    @(negedge hs_clk);
    chk("midrst_outputs", all_outs(), 64'd0);
    rst = 1'b0; rx_active_hs = 1'b0;
    repeat (3) @(posedge hs_clk);
    @(negedge hs_clk);
    chk("midrst_silent", {32'(n_ecc - b_ecc), 32'(n_trunc - b_trunc)}, 64'd0);

    // Next burst after reset: FE short packet
    snap();
    tx = '{{2'b00, DT_FE}, 8'h01, 8'h00, 8'h1D};
    send(1'b0, -1);
    chk("postrst_hdr", {32'(n_hdr - b_hdr), 7'd0, cap_short, hdr_dt, hdr_wc}, {32'd1, 8'd1, DT_FE, 16'h0001});
    chk("postrst_quiet", {32'(n_data - b_data), 32'(n_ecc - b_ecc + n_trunc - b_trunc)}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
